// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types, defaults and width helper for the matrix/vector feeder
package feeder_pkg;

   localparam int FEED_DATA_W = 8;
   localparam int FEED_MAX_N  = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_MAT,
      LOAD_VEC,
      DONE_MAT,
      DONE_VEC
   } feeder_state_e;

   // Index width for MAX_N banks; a single bank still gets a 1-bit index.
   function automatic int idx_width(input int max_n);
      return (max_n > 2) ? $clog2(max_n) : 1;
   endfunction

endpackage

// File: rtl/feeder_idx_counter.sv
// rtl/feeder_idx_counter.sv - two-level wrap counter (inner/outer, terminal N-1) with last-beat flag
module feeder_idx_counter
   import feeder_pkg::*;
#(
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             step,
   input  logic             two_level,
   input  logic [IDX_W-1:0] last_val,
   output logic [IDX_W-1:0] inner,
   output logic [IDX_W-1:0] outer,
   output logic             last
);

   logic inner_wrap;
   logic outer_wrap;

   assign inner_wrap = (inner == last_val);
   assign outer_wrap = (outer == last_val);

   // Single-level use (vector phase) finishes as soon as the inner index wraps.
   assign last = inner_wrap && (!two_level || outer_wrap);

   always_ff @(posedge clk) begin
      if (rst || init) begin
         inner <= '0;
         outer <= '0;
      end else if (step) begin
         if (inner_wrap) begin
            inner <= '0;
            if (two_level) begin
               outer <= outer_wrap ? '0 : outer + IDX_W'(1);
            end
         end else begin
            inner <= inner + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/mat_vec_feeder.sv
// rtl/mat_vec_feeder.sv - routes a received element stream into column RAM banks and the vector register
module mat_vec_feeder
   import feeder_pkg::*;
#(
   parameter  int DATA_W = FEED_DATA_W,
   parameter  int MAX_N  = FEED_MAX_N,
   localparam int IDX_W  = idx_width(MAX_N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              size_wr,
   input  logic              mat_start,
   input  logic              vec_start,
   input  logic              col_major,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              ram_we,
   output logic [IDX_W-1:0]  ram_sel,
   output logic [IDX_W-1:0]  ram_addr,
   output logic              vec_we,
   output logic [IDX_W-1:0]  vec_idx,
   output logic [DATA_W-1:0] wr_data,
   output logic [IDX_W:0]    size_q,
   output logic              size_err,
   output logic              mat_done,
   output logic              vec_done
);

   feeder_state_e    state;
   feeder_state_e    state_nxt;

   logic             wipe;
   logic             beat;
   logic             size_legal;
   logic             start_mat;
   logic             start_vec;
   logic             in_load;
   logic             mode_cm;
   logic [IDX_W:0]   size_m1;
   logic [IDX_W-1:0] cnt_inner;
   logic [IDX_W-1:0] cnt_outer;
   logic             cnt_last;

   assign wipe       = rst || clear;
   assign in_load    = (state == LOAD_MAT) || (state == LOAD_VEC);
   assign beat       = rx_valid && rx_ready;
   assign size_legal = (rx_data != '0) && (rx_data <= DATA_W'(MAX_N));
   assign size_m1    = size_q - (IDX_W+1)'(1);

   // size_wr outranks mat_start, which outranks vec_start, on the same edge.
   assign start_mat = (state == IDLE) && !size_wr && mat_start && (size_q != '0);
   assign start_vec = (state == IDLE) && !size_wr && !mat_start && vec_start && (size_q != '0);

   feeder_idx_counter #(.IDX_W(IDX_W)) u_cnt (
      .clk       (clk),
      .rst       (wipe),
      .init      (!in_load),
      .step      (beat),
      .two_level (state == LOAD_MAT),
      .last_val  (size_m1[IDX_W-1:0]),
      .inner     (cnt_inner),
      .outer     (cnt_outer),
      .last      (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (wipe) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_mat) begin
               state_nxt = LOAD_MAT;
            end else if (start_vec) begin
               state_nxt = LOAD_VEC;
            end
         end
         LOAD_MAT: if (beat && cnt_last) state_nxt = DONE_MAT;
         LOAD_VEC: if (beat && cnt_last) state_nxt = DONE_VEC;
         DONE_MAT: state_nxt = IDLE;
         DONE_VEC: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_ready = in_load;
   end

   // Done pulses are taken from the DONE state so they land one cycle after the final strobe.
   always_ff @(posedge clk) begin
      if (wipe) begin
         ram_we   <= 1'b0;
         ram_sel  <= '0;
         ram_addr <= '0;
         vec_we   <= 1'b0;
         vec_idx  <= '0;
         wr_data  <= '0;
         size_q   <= '0;
         size_err <= 1'b0;
         mat_done <= 1'b0;
         vec_done <= 1'b0;
         mode_cm  <= 1'b0;
      end else begin
         ram_we   <= 1'b0;
         vec_we   <= 1'b0;
         mat_done <= (state == DONE_MAT);
         vec_done <= (state == DONE_VEC);
         if ((state == IDLE) && size_wr) begin
            if (size_legal) begin
               size_q   <= rx_data[IDX_W:0];
               size_err <= 1'b0;
            end else begin
               size_err <= 1'b1;
            end
         end
         if (start_mat) begin
            mode_cm <= col_major;
         end
         if (beat) begin
            wr_data <= rx_data;
            if (state == LOAD_MAT) begin
               ram_we   <= 1'b1;
               ram_sel  <= mode_cm ? cnt_outer : cnt_inner;
               ram_addr <= mode_cm ? cnt_inner : cnt_outer;
            end else begin
               vec_we  <= 1'b1;
               vec_idx <= cnt_inner;
            end
         end
      end
   end

endmodule

// File: tb/tb_mat_vec_feeder.sv
// tb/tb_mat_vec_feeder.sv - directed and randomized self-checking bench for mat_vec_feeder
module tb_mat_vec_feeder;

   localparam int DATA_W = 8;
   localparam int MAX_N  = 8;
   localparam int IDX_W  = 3;

   logic              clk = 1'b0;
   logic              rst, clear, size_wr, mat_start, vec_start, col_major, rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              rx_ready, ram_we, vec_we, size_err, mat_done, vec_done;
   logic [IDX_W-1:0]  ram_sel, ram_addr, vec_idx;
   logic [DATA_W-1:0] wr_data;
   logic [IDX_W:0]    size_q;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int sel;
      int addr;
      int data;
      int cyc;
   } wr_t;

   wr_t mat_q[$];
   wr_t vec_q[$];
   int  mat_done_q[$];
   int  vec_done_q[$];
   int  beat_cyc[$];
   int  stim[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mat_vec_feeder #(.DATA_W(DATA_W), .MAX_N(MAX_N)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .size_wr   (size_wr),
      .mat_start (mat_start),
      .vec_start (vec_start),
      .col_major (col_major),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .ram_we    (ram_we),
      .ram_sel   (ram_sel),
      .ram_addr  (ram_addr),
      .vec_we    (vec_we),
      .vec_idx   (vec_idx),
      .wr_data   (wr_data),
      .size_q    (size_q),
      .size_err  (size_err),
      .mat_done  (mat_done),
      .vec_done  (vec_done)
   );

   always @(negedge clk) begin
      if (ram_we === 1'b1) mat_q.push_back('{int'(ram_sel), int'(ram_addr), int'(wr_data), cyc});
      if (vec_we === 1'b1) vec_q.push_back('{0, int'(vec_idx), int'(wr_data), cyc});
      if (mat_done === 1'b1) mat_done_q.push_back(cyc);
      if (vec_done === 1'b1) vec_done_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_reset();
      mat_q.delete();
      vec_q.delete();
      mat_done_q.delete();
      vec_done_q.delete();
      beat_cyc.delete();
   endtask

   task automatic do_size(input int val);
      size_wr = 1'b1;
      rx_data = DATA_W'(val);
      step();
      size_wr = 1'b0;
   endtask

   // gap_mode: 0 contiguous, 1 random idle cycles, 2 one idle cycle after every beat
   task automatic send(input int count, input int gap_mode);
      for (int k = 0; k < count; k++) begin
         if (gap_mode == 1) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
               rx_valid = 1'b0;
               step();
            end
         end
         rx_valid = 1'b1;
         rx_data  = DATA_W'(stim[k]);
         if (k == 0) chk("rx_ready_in_load", rx_ready, 1);
         beat_cyc.push_back(cyc);
         step();
         if (gap_mode == 2) begin
            rx_valid = 1'b0;
            step();
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic fill_random(input int count);
      stim.delete();
      for (int k = 0; k < count; k++) stim.push_back(int'($urandom_range(0, 255)));
   endtask

   task automatic run_matrix(input int n, input bit cm, input int gap_mode);
      mon_reset();
      col_major = cm;
      mat_start = 1'b1;
      step();
      mat_start = 1'b0;
      col_major = 1'b0;
      send(n * n, gap_mode);
      repeat (3) step();
   endtask

   // Element k of the stream sits at position (k mod n, k div n) of the stream's own ordering.
   task automatic check_matrix(input string tag, input int n, input bit cm, input int nbeats);
      int mismatches;
      int max_idx;
      mismatches = 0;
      max_idx    = 0;
      chk({tag, "_write_count"}, mat_q.size(), nbeats);
      for (int k = 0; k < nbeats && k < mat_q.size(); k++) begin
         int fast, slow;
         fast = k % n;
         slow = k / n;
         if (mat_q[k].sel  != (cm ? slow : fast)) mismatches++;
         if (mat_q[k].addr != (cm ? fast : slow)) mismatches++;
         if (mat_q[k].data != stim[k]) mismatches++;
         if (mat_q[k].cyc  != beat_cyc[k] + 1) mismatches++;
         if (mat_q[k].sel  > max_idx) max_idx = mat_q[k].sel;
         if (mat_q[k].addr > max_idx) max_idx = mat_q[k].addr;
      end
      chk({tag, "_sel_addr_data_mismatches"}, mismatches, 0);
      chk({tag, "_max_index_below_n"}, (max_idx <= n - 1), 1);
      if (nbeats == n * n) begin
         chk({tag, "_done_pulses"}, mat_done_q.size(), 1);
         if (mat_done_q.size() > 0 && mat_q.size() > 0)
            chk({tag, "_done_after_last_strobe"}, mat_done_q[0], mat_q[mat_q.size()-1].cyc + 1);
      end
      chk({tag, "_rx_ready_after"}, rx_ready, 0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; size_wr = 1'b0; mat_start = 1'b0; vec_start = 1'b0;
      col_major = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (2) step();
      rst = 1'b0;
      step();

      chk("reset_rx_ready", rx_ready, 0);
      chk("reset_strobes", {ram_we, vec_we, mat_done, vec_done, size_err}, 0);
      chk("reset_size_q", size_q, 0);
      chk("reset_indices", {ram_sel, ram_addr, vec_idx, wr_data}, 0);

      // start with no size loaded is ignored, and a stray rx_valid is not consumed
      mon_reset();
      mat_start = 1'b1;
      rx_valid  = 1'b1;
      step();
      mat_start = 1'b0;
      vec_start = 1'b1;
      step();
      vec_start = 1'b0;
      rx_valid  = 1'b0;
      repeat (2) step();
      chk("no_size_start_ignored_ready", rx_ready, 0);
      chk("no_size_start_ignored_writes", mat_q.size() + vec_q.size(), 0);

      // N=3 row-major, contiguous 0x10..0x18
      do_size(3);
      chk("size3_loaded", size_q, 3);
      chk("size3_err_clear", size_err, 0);
      stim.delete();
      for (int k = 0; k < 9; k++) stim.push_back(16 + k);
      run_matrix(3, 1'b0, 0);
      check_matrix("n3_row", 3, 1'b0, 9);

      // illegal sizes keep the previous N
      do_size(0);
      chk("size0_err", size_err, 1);
      chk("size0_keeps_q", size_q, 3);
      do_size(MAX_N + 1);
      chk("size9_err", size_err, 1);
      chk("size9_keeps_q", size_q, 3);
      do_size(8'h83);
      chk("size_hibit_err", size_err, 1);
      chk("size_hibit_keeps_q", size_q, 3);

      // N=2 column-major
      do_size(2);
      chk("size2_err_cleared", size_err, 0);
      fill_random(4);
      run_matrix(2, 1'b1, 1);
      check_matrix("n2_col", 2, 1'b1, 4);

      // N=4 vector, valid every other cycle
      do_size(4);
      mon_reset();
      fill_random(4);
      vec_start = 1'b1;
      step();
      vec_start = 1'b0;
      send(4, 2);
      repeat (3) step();
      chk("vec_write_count", vec_q.size(), 4);
      for (int k = 0; k < vec_q.size() && k < 4; k++) begin
         chk($sformatf("vec_idx_%0d", k), vec_q[k].addr, k);
         chk($sformatf("vec_data_%0d", k), vec_q[k].data, stim[k]);
         chk($sformatf("vec_latency_%0d", k), vec_q[k].cyc, beat_cyc[k] + 1);
      end
      chk("vec_done_pulses", vec_done_q.size(), 1);
      if (vec_done_q.size() > 0 && vec_q.size() > 0)
         chk("vec_done_after_last", vec_done_q[0], vec_q[vec_q.size()-1].cyc + 1);
      chk("vec_no_matrix_writes", mat_q.size(), 0);
      chk("vec_rx_ready_after", rx_ready, 0);

      // size_wr ignored mid-load, then clear after 5 of 9 beats with a 6th beat on the clear edge
      do_size(3);
      mon_reset();
      fill_random(9);
      mat_start = 1'b1;
      step();
      mat_start = 1'b0;
      size_wr = 1'b1;
      rx_data = 8'd7;
      step();
      size_wr = 1'b0;
      chk("size_locked_mid_load", size_q, 3);
      send(5, 0);
      clear    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hEE;
      step();
      clear    = 1'b0;
      rx_valid = 1'b0;
      chk("clear_rx_ready", rx_ready, 0);
      chk("clear_size_q", size_q, 0);
      chk("clear_ram_we", ram_we, 0);
      rx_valid = 1'b1;
      repeat (4) step();
      rx_valid = 1'b0;
      check_matrix("clear_partial", 3, 1'b0, 5);
      chk("clear_no_done", mat_done_q.size(), 0);

      // N=MAX_N full matrix with random gaps, both orderings
      do_size(MAX_N);
      chk("size_max_loaded", size_q, MAX_N);
      fill_random(MAX_N * MAX_N);
      run_matrix(MAX_N, 1'b0, 1);
      check_matrix("n8_row", MAX_N, 1'b0, MAX_N * MAX_N);
      fill_random(MAX_N * MAX_N);
      run_matrix(MAX_N, 1'b1, 1);
      check_matrix("n8_col", MAX_N, 1'b1, MAX_N * MAX_N);

      // random small sizes and orderings
      for (int t = 0; t < 4; t++) begin
         int n;
         bit cm;
         n  = int'($urandom_range(1, MAX_N));
         cm = 1'($urandom_range(0, 1));
         do_size(n);
         fill_random(n * n);
         run_matrix(n, cm, 1);
         check_matrix($sformatf("rand%0d_n%0d_cm%0d", t, n, cm), n, cm, n * n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mat_vec_feeder.md
Name: mat_vec_feeder

Overview:
- Parametrised successor of the UART-to-accelerator data feeder.
- Takes a byte stream from the receiver: matrix dimension N, then N*N matrix elements, then N vector elements.
- Routes each matrix element to one of MAX_N column RAMs (RAM index and address), and each vector element to the PIPO vector register index.
- Adds valid/ready handshake, size checking, row/column-major mode, and done pulses.

Parameters:
DATA_W, 8, width of one received element
MAX_N, 8, maximum matrix dimension (number of RAM banks)
IDX_W, $clog2(MAX_N) (min 1), width of RAM index, address and vector index (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous soft clear, same effect as rst
size_wr  in  1  load N from rx_data (IDLE only)
mat_start  in  1  begin matrix load (IDLE only, needs valid N)
vec_start  in  1  begin vector load (IDLE only, needs valid N)
col_major  in  1  sampled at mat_start; 0 = row-major stream, 1 = column-major stream
rx_valid  in  1  rx_data holds an element
rx_data  in  DATA_W  received byte/element
rx_ready  out  1  feeder accepts element this cycle
ram_we  out  1  matrix write strobe
ram_sel  out  IDX_W  target RAM bank
ram_addr  out  IDX_W  address inside bank
vec_we  out  1  vector write strobe
vec_idx  out  IDX_W  PIPO vector index
wr_data  out  DATA_W  element being written
size_q  out  IDX_W+1  currently loaded N
size_err  out  1  sticky, last size_wr was illegal
mat_done  out  1  one-cycle pulse after last matrix write
vec_done  out  1  one-cycle pulse after last vector write

Behaviour:
- Reset/clear values:
  - All outputs 0; state IDLE; size_q 0.
  - rst and clear take effect on the same edge, from any state, and abort any load in progress.
  - No partial write is issued after a clear.
- Priority on an edge: rst > clear > size_wr > mat_start > vec_start > beat acceptance.
- States and transitions:
  - IDLE: rx_ready 0.
    - size_wr with rx_data in 1..MAX_N: size_q <= rx_data, size_err <= 0.
    - size_wr with any other value: size_q unchanged, size_err <= 1.
    - mat_start with size_q != 0: go to LOAD_MAT, row=col=0, latch col_major. If size_q = 0, ignore it.
    - vec_start with size_q != 0: go to LOAD_VEC, idx=0. If size_q = 0, ignore it.
  - LOAD_MAT: rx_ready 1.
    - Beat = rx_valid & rx_ready.
    - On each beat, next cycle: ram_we=1, wr_data=element.
    - Row-major: ram_sel=col, ram_addr=row.
    - Column-major: ram_sel=row, ram_addr=col.
    - Counter: inner index wraps at N-1 and increments the outer index. After beat N*N, go to DONE_MAT.
  - LOAD_VEC: rx_ready 1.
    - On each beat, next cycle: vec_we=1, vec_idx=idx, wr_data=element.
    - After beat N, go to DONE_VEC.
  - DONE_MAT / DONE_VEC: rx_ready 0. Assert mat_done/vec_done for exactly one cycle, then return to IDLE.
- Latency and output behaviour:
  - Write latency: exactly 1 cycle from accepted beat to strobe; all outputs registered.
  - The done pulse occurs the cycle after the final strobe.
  - No beat is accepted without rx_valid; counters hold while rx_valid is 0. Gaps of any length are legal.
  - Strobes are 0 on non-beat cycles; sel/addr/idx/wr_data hold their last values.
- Ignored inputs:
  - size_wr, mat_start and vec_start are ignored outside IDLE; size_q cannot change mid-load.
  - rx_valid in IDLE, DONE_MAT or DONE_VEC is not consumed.
- Width rules:
  - size_q is IDX_W+1 bits so that MAX_N is representable.
  - Indices never exceed N-1.
  - Upper bits of rx_data above IDX_W+1 bits must be 0 for a legal size.

Decomposition:
- Package feeder_pkg:
  - feeder_state_e enum (IDLE, LOAD_MAT, LOAD_VEC, DONE_MAT, DONE_VEC)
  - FEED_DATA_W and FEED_MAX_N defaults
  - IDX_W derivation function
- Sub-module feeder_idx_counter:
  - Two-level wrap counter (inner/outer, terminal value N-1).
  - Provides a last-beat flag.
  - Instantiated once and reused for both the matrix and vector phases.

Test Plan:
- N=3, row-major, 9 contiguous beats 0x10..0x18 -> ram_we 9 cycles; (sel,addr) sequence (0,0),(1,0),(2,0),(0,1)..(2,2); data matches; mat_done one cycle after 9th strobe.
- N=2, col_major=1, beats A,B,C,D -> (sel,addr) = (0,0),(0,1),(1,0),(1,1).
- size_wr with rx_data=0 and with rx_data=MAX_N+1 -> size_err=1, size_q unchanged; mat_start then ignored when size_q=0.
- N=4 vector with rx_valid toggling every other cycle -> vec_idx 0,1,2,3 one cycle after each beat; vec_done once; rx_ready 0 afterwards.
- clear asserted after 5 of 9 matrix beats -> next cycle IDLE, size_q=0, no further ram_we; new size/load then completes normally.
- N=MAX_N=8 full matrix -> 64 writes; indices reach 7 and wrap; no index exceeds 7.
